// File: rtl/bilbo_pkg.sv
// BILBO register shared definitions:
// mode encodings and session FSM states.
package bilbo_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SCAN = 2'b00;
  localparam mode_t MODE_SEED = 2'b01;
  localparam mode_t MODE_LFSR = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/bilbo_lfsr_step.sv
// One Fibonacci LFSR/MISR step, combinational.
// Shared so multi-register BIST rings can reuse it.
module bilbo_lfsr_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] q_i,
  input  logic [N-1:0] d_i,
  input  logic         sel_misr_i,
  input  logic [N-1:0] poly_i,
  output logic [N-1:0] nxt_o
);

  logic         fb;
  logic [N-1:0] inj;

  // Feedback parity, optional data injection.
  always_comb begin
    fb    = ^(q_i & poly_i);
    inj   = sel_misr_i ? d_i : '0;
    nxt_o = {q_i[N-2:0], fb} ^ inj;
  end

endmodule

// File: rtl/bilbo_bist_reg.sv
// BILBO register (load/scan/seed/LFSR) with
// a counted self-test session and signature check.
module bilbo_bist_reg
  import bilbo_pkg::*;
#(
  parameter int           N    = 8,
  parameter logic [N-1:0] POLY = 8'hB8,
  parameter logic [N-1:0] SEED = 8'h01,
  parameter int           CW   = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          C1,
  input  logic          C2,
  input  logic          SEL_MISR,
  input  logic [N-1:0]  D,
  input  logic          SI,
  input  logic          START,
  input  logic [CW-1:0] NPAT,
  input  logic [N-1:0]  GOLDEN,
  output logic [N-1:0]  Q,
  output logic [N-1:0]  QBAR,
  output logic          SO,
  output logic          BUSY,
  output logic          DONE,
  output logic          PASS
);

  mode_t         mode;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  step_w;
  state_t        st_q;
  logic [CW-1:0] cnt_q;
  logic          done_q, pass_q;
  logic          cmp_q;
  logic          run;
  logic          match;

  assign mode  = {C1, C2};
  assign run   = (st_q == ST_RUN);
  assign match = (q_q == GOLDEN);

  bilbo_lfsr_step #(.N(N)) u_step (
    .q_i       (q_q),
    .d_i       (D),
    .sel_misr_i(SEL_MISR),
    .poly_i    (POLY),
    .nxt_o     (step_w)
  );

  // Register next value by mode; LFSR only steps in RUN.
  always_comb begin
    q_d = q_q;
    unique case (mode)
      MODE_LOAD: q_d = D;
      MODE_SCAN: q_d = {q_q[N-2:0], SI};
      MODE_SEED: q_d = SEED;
      MODE_LFSR: q_d = run ? step_w : q_q;
      default:   q_d = q_q;
    endcase
  end

  // Datapath register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) q_q <= SEED;
    else     q_q <= q_d;
  end

  // Session FSM, step counter and result flags.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      cmp_q  <= 1'b0;
    end else begin
      case (st_q)
        ST_RUN: begin
          if (mode == MODE_LFSR) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              st_q  <= ST_FIN;
              cmp_q <= 1'b1;
            end
          end
        end
        default: begin
          if (START) begin
            cmp_q <= 1'b0;
            if (NPAT != '0) begin
              st_q   <= ST_RUN;
              cnt_q  <= NPAT;
              done_q <= 1'b0;
              pass_q <= 1'b0;
            end else begin
              st_q   <= ST_FIN;
              done_q <= 1'b1;
              pass_q <= match;
            end
          end else if (cmp_q) begin
            // Final signature is stable now.
            cmp_q  <= 1'b0;
            done_q <= 1'b1;
            pass_q <= match;
          end
        end
      endcase
    end
  end

  assign Q    = q_q;
  assign QBAR = ~q_q;
  assign SO   = q_q[N-1];
  assign BUSY = run;
  assign DONE = done_q;
  assign PASS = pass_q;

endmodule

// File: tb/tb_bilbo_bist_reg.sv
// Directed bench for bilbo_bist_reg with a
// queue scoreboard of expected values.
module tb_bilbo_bist_reg;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        C1 = 1'b0, C2 = 1'b0;
  logic        SEL_MISR = 1'b0;
  logic [7:0]  D = '0;
  logic        SI = 1'b0;
  logic        START = 1'b0;
  logic [15:0] NPAT = '0;
  logic [7:0]  GOLDEN = '0;
  logic [7:0]  Q, QBAR;
  logic        SO, BUSY, DONE, PASS;

  int ntot  = 0;
  int npass = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];

  bilbo_bist_reg #(
    .N(8), .POLY(8'hB8), .SEED(8'h01), .CW(16)
  ) dut (
    .CLK(CLK), .RST(RST), .C1(C1), .C2(C2),
    .SEL_MISR(SEL_MISR), .D(D), .SI(SI),
    .START(START), .NPAT(NPAT), .GOLDEN(GOLDEN),
    .Q(Q), .QBAR(QBAR), .SO(SO),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] o);
    exp_t e;
    ntot++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty obs=%h exp=queued", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.v) npass++;
      else $error("FAIL %s obs=%h exp=%h", e.tag, o, e.v);
    end
  endtask

  task automatic mode(input logic [1:0] m);
    {C1, C2} = m;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] st();
    return {29'd0, BUSY, DONE, PASS};
  endfunction

  logic [7:0] prpg[5];

  initial begin
    prpg[0] = 8'h02; prpg[1] = 8'h04; prpg[2] = 8'h08;
    prpg[3] = 8'h11; prpg[4] = 8'h23;

    // 1: async reset mid-cycle
    #2 RST = 1'b1;
    push("rst_q", 8'h01);
    push("rst_qbar", 8'hFE);
    push("rst_flags", 3'b000);
    #1;
    chk(Q); chk(QBAR); chk(st());
    #6 RST = 1'b0;
    @(negedge CLK);

    // 2: load then scan
    mode(2'b11); D = 8'hA5;
    push("load", 8'hA5);
    step(); chk(Q);
    mode(2'b00); SI = 1'b1;
    push("scan_q", 8'h4B);
    push("scan_so", 1'b0);
    step(); chk(Q); chk(SO);

    // 3: PRPG session, NPAT=5
    mode(2'b01);
    push("seed", 8'h01);
    step(); chk(Q);
    mode(2'b10); SEL_MISR = 1'b0;
    GOLDEN = 8'h23; NPAT = 16'd5; START = 1'b1;
    push("p_start_q", 8'h01);
    push("p_start_st", 3'b100);
    step(); chk(Q); chk(st());
    START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push("p_q", prpg[i]);
      push("p_st", (i < 4) ? 3'b100 : 3'b000);
      step(); chk(Q); chk(st());
    end
    push("p_done", 3'b011);
    step(); chk(st());
    push("p_sticky", 3'b011);
    push("p_hold", 8'h23);
    step(); chk(st()); chk(Q);

    // 4: MISR single step, pass then fail
    for (int k = 0; k < 2; k++) begin
      mode(2'b01); step();
      mode(2'b10); SEL_MISR = 1'b1; D = 8'hFF;
      GOLDEN = (k == 0) ? 8'hFD : 8'h00;
      NPAT = 16'd1; START = 1'b1;
      push("m_start", 3'b100);
      step(); chk(st());
      START = 1'b0;
      push("m_q", 8'hFD);
      step(); chk(Q);
      push("m_res", (k == 0) ? 3'b011 : 3'b010);
      step(); chk(st());
    end

    // 5: pause mid-session, START ignored
    mode(2'b01); step();
    mode(2'b10); SEL_MISR = 1'b0;
    GOLDEN = 8'hE7; NPAT = 16'd4; START = 1'b1;
    step();
    START = 1'b0;
    push("r_s1", 8'h02);
    step(); chk(Q);
    mode(2'b11); D = 8'h3C;
    START = 1'b1; NPAT = 16'd9;
    step();
    START = 1'b0;
    push("r_ld_q", 8'h3C);
    push("r_ld_st", 3'b100);
    step(); chk(Q); chk(st());
    mode(2'b10);
    push("r_s2", 8'h79);
    step(); chk(Q);
    push("r_s3", 8'hF3);
    step(); chk(Q);
    push("r_s4_q", 8'hE7);
    push("r_s4_st", 3'b000);
    step(); chk(Q); chk(st());
    push("r_done", 3'b011);
    push("r_hold", 8'hE7);
    step(); chk(st()); chk(Q);

    // 6: NPAT=0, then reset during RUN
    GOLDEN = 8'h00; NPAT = 16'd0; START = 1'b1;
    push("z_q", 8'hE7);
    push("z_st", 3'b010);
    step(); chk(Q); chk(st());
    START = 1'b0;
    GOLDEN = 8'hE7; NPAT = 16'd5; START = 1'b1;
    push("a_run", 3'b100);
    step(); chk(st());
    START = 1'b0;
    step();
    #2 RST = 1'b1;
    push("a_q", 8'h01);
    push("a_st", 3'b000);
    #1; chk(Q); chk(st());
    #1 RST = 1'b0;
    push("a_idle_q", 8'h01);
    push("a_idle_st", 3'b000);
    step(); chk(Q); chk(st());

    ntot++;
    assert (sb.size() === 0) npass++;
    else $error("FAIL sb_drain obs=%0d exp=0", sb.size());

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
